// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 16x4 shift-add multiplier among
// NUM_REQ requesters; returns product and a one-cycle ack per grant.
//
// Ports:
//   clock, reset             rising-edge clock, sync active-high reset
//   req[NUM_REQ]             level requests, held until ack
//   req_mult/req_mcand       packed per-requester operands (16b / 4b)
//   ack[NUM_REQ]             completion pulse to the served requester
//   result[20], err          product / timeout flag, valid with ack
//   busy, grant_id[3]        not-idle flag, current/last winner
//   mul_St/Mult/Mcand        start and operands to the multiplier
//   mul_product/mul_Done     multiplier result and completion
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_mult,
    input  logic [4*NUM_REQ-1:0]   req_mcand,
    output logic [NUM_REQ-1:0]     ack,
    output logic [19:0]            result,
    output logic                   err,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   mul_St,
    output logic [15:0]            mul_Mult,
    output logic [3:0]             mul_Mcand,
    input  logic [19:0]            mul_product,
    input  logic                   mul_Done
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_BLANK, S_WAIT, S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_rr;
    logic [2:0]      r_grant;
    logic [CW-1:0]   r_cnt;
    logic [19:0]     r_result;
    logic            r_err;
    logic [15:0]     r_mult;
    logic [3:0]      r_mcand;

    logic            w_found;
    logic [2:0]      w_win;
    logic [15:0]     w_mult;
    logic [3:0]      w_mcand;
    logic            w_timeout;
    logic [15:0]     w_opm [NUM_REQ];
    logic [3:0]      w_opc [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
        assign w_opm[g] = req_mult[g*16 +: 16];
        assign w_opc[g] = req_mcand[g*4 +: 4];
    end

    // Scan starting at the rr pointer; first active request wins.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = r_rr;
        w_mult  = '0;
        w_mcand = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!w_found && req[idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = 3'(idx);
                w_mult  = w_opm[idx[IW-1:0]];
                w_mcand = w_opc[idx[IW-1:0]];
            end
        end
    end

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // St and ack are gated by reset so an abort never leaks a pulse.
    always_comb begin
        w_next = r_state;
        mul_St = 1'b0;
        ack    = '0;
        busy   = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: begin
                mul_St = !reset;
                w_next = S_BLANK;
            end
            S_BLANK: w_next = S_WAIT;
            S_WAIT:  if (mul_Done || w_timeout) w_next = S_RESP;
            S_RESP: begin
                if (!reset)
                    ack = NUM_REQ'(1) << r_grant;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr     <= '0;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_mult   <= '0;
            r_mcand  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_win;
                        r_mult  <= w_mult;
                        r_mcand <= w_mcand;
                    end
                end
                // Done may be stale from the prior op here; ignore it.
                S_BLANK: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mul_Done) begin
                        r_result <= mul_product;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (r_grant == 3'(NUM_REQ - 1))
                        r_rr <= '0;
                    else
                        r_rr <= r_grant + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign result    = r_result;
    assign err       = r_err;
    assign grant_id  = r_grant;
    assign mul_Mult  = r_mult;
    assign mul_Mcand = r_mcand;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural
// shift-add multiplier model (fixed latency, sticky Done).
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int TO  = 64;
    localparam int LAT = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [16*N-1:0]  req_mult = '0;
    logic [4*N-1:0]   req_mcand = '0;
    logic [N-1:0]     ack;
    logic [19:0]      result;
    logic             err;
    logic             busy;
    logic [2:0]       grant_id;
    logic             mul_St;
    logic [15:0]      mul_Mult;
    logic [3:0]       mul_Mcand;
    logic [19:0]      mul_product = '0;
    logic             mul_Done = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         id;
        logic [19:0] res;
        logic        e;
    } exp_t;

    exp_t sb[$];

    bit hang = 1'b0;
    int mc   = 0;
    int it_st_first;
    int it_ack;
    int n_st;

    always #5 clock = ~clock;

    mult_share_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_mult    (req_mult),
        .req_mcand   (req_mcand),
        .ack         (ack),
        .result      (result),
        .err         (err),
        .busy        (busy),
        .grant_id    (grant_id),
        .mul_St      (mul_St),
        .mul_Mult    (mul_Mult),
        .mul_Mcand   (mul_Mcand),
        .mul_product (mul_product),
        .mul_Done    (mul_Done)
    );

    // Multiplier model: Done stays high until one cycle after the
    // next St, and the product uses the operands seen at completion.
    always @(posedge clock) begin
        if (mul_St) begin
            mc <= LAT;
        end else if (mc > 0) begin
            mc <= mc - 1;
            if (mc == LAT)
                mul_Done <= 1'b0;
            if (mc == 1 && !hang) begin
                mul_Done    <= 1'b1;
                mul_product <= 20'(mul_Mult) * 20'(mul_Mcand);
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(int id, int m, int c, logic e);
        exp_t s;
        s.id  = id;
        s.res = e ? 20'd0 : 20'(m * c);
        s.e   = e;
        sb.push_back(s);
    endtask

    task automatic set_ops(int i, int m, int c);
        req_mult  = (req_mult & ~((16*N)'(16'hFFFF) << (16*i)))
                  | ((16*N)'(16'(m)) << (16*i));
        req_mcand = (req_mcand & ~((4*N)'(4'hF) << (4*i)))
                  | ((4*N)'(4'(c)) << (4*i));
    endtask

    task automatic wait_acks(int n, int budget, bit drop);
        int got = 0;
        int it  = 0;
        it_st_first = 0;
        it_ack      = 0;
        n_st        = 0;
        while (got < n && it < budget) begin
            @(negedge clock);
            it++;
            if (mul_St === 1'b1) begin
                n_st++;
                if (it_st_first == 0)
                    it_st_first = it;
            end
            if (ack !== '0) begin
                got++;
                it_ack = it;
                if (drop)
                    req = req & ~ack;
            end
        end
        req = '0;
        if (got < n)
            chk("ack_wait_budget", 32'(got), 32'(n));
    endtask

    // Monitor: every ack pops the next expected response.
    initial begin
        exp_t s;
        forever begin
            @(negedge clock);
            if (ack !== '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    s = sb.pop_front();
                    chk("ack_vec", 32'(ack), 32'(1 << s.id));
                    chk("grant_id", 32'(grant_id), 32'(s.id));
                    chk("result", 32'(result), 32'(s.res));
                    chk("err", 32'(err), 32'(s.e));
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_st", 32'(mul_St), 32'd0);
        chk("rst_mult", 32'(mul_Mult), 32'd0);
        chk("rst_mcand", 32'(mul_Mcand), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Contention from rr=0: 0 then 1.
        set_ops(0, 20, 8);
        set_ops(1, 18, 5);
        push(0, 20, 8, 1'b0);
        push(1, 18, 5, 1'b0);
        req = 4'b0011;
        wait_acks(2, 400, 1'b1);
        @(negedge clock);

        // Single request with a stale Done left high.
        set_ops(0, 18, 5);
        push(0, 18, 5, 1'b0);
        req[0] = 1'b1;
        wait_acks(1, 200, 1'b1);
        chk("single_st_cycles", 32'(n_st), 32'd1);
        chk("single_st_latency", 32'(it_st_first), 32'd1);
        chk("single_ack_latency", 32'(it_ack), 32'(LAT + 3));
        chk("busy_in_resp", 32'(busy), 32'd1);
        @(negedge clock);
        chk("busy_after_ack", 32'(busy), 32'd0);

        // Max operands; inputs change while waiting.
        set_ops(2, 65535, 15);
        push(2, 65535, 15, 1'b0);
        req[2] = 1'b1;
        repeat (4) @(negedge clock);
        set_ops(2, 16'h1234, 2);
        @(negedge clock);
        chk("hold_mult", 32'(mul_Mult), 32'd65535);
        chk("hold_mcand", 32'(mul_Mcand), 32'd15);
        wait_acks(1, 200, 1'b1);
        @(negedge clock);

        // Timeout: Done never rises.
        hang = 1'b1;
        set_ops(3, 7, 3);
        push(3, 0, 0, 1'b1);
        req[3] = 1'b1;
        wait_acks(1, 200, 1'b1);
        chk("timeout_latency", 32'(it_ack), 32'(TO + 3));
        hang = 1'b0;
        @(negedge clock);

        // All four held: rr pointer is back at 0.
        for (int i = 0; i < N; i++)
            set_ops(i, 100 + i, i + 1);
        for (int r = 0; r < 8; r++)
            push(r % N, 100 + (r % N), (r % N) + 1, 1'b0);
        req = 4'hF;
        wait_acks(8, 1000, 1'b0);
        @(negedge clock);

        // Advance rr to 3, then abort an op on requester 0.
        set_ops(2, 2, 2);
        push(2, 2, 2, 1'b0);
        req[2] = 1'b1;
        wait_acks(1, 200, 1'b1);
        @(negedge clock);
        set_ops(0, 11, 11);
        req[0] = 1'b1;
        repeat (4) @(negedge clock);
        chk("abort_in_wait_busy", 32'(busy), 32'd1);
        req   = '0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_grant", 32'(grant_id), 32'd0);
        chk("abort_mult", 32'(mul_Mult), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        repeat (8) @(negedge clock);

        // rr reset to 0: requester 1 beats 3.
        set_ops(1, 20, 8);
        set_ops(3, 5, 5);
        push(1, 20, 8, 1'b0);
        push(3, 5, 5, 1'b0);
        req = 4'b1010;
        wait_acks(2, 400, 1'b1);
        repeat (3) @(negedge clock);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin scheduler that shares one 16x4 shift-add multiplier (multiplier_Top: St/Mult/Mcand in, product/Done out) among NUM_REQ requesters.
- Latches the winning requester's operands, pulses St, waits for Done (with timeout), and returns the 20-bit product plus a one-cycle ack to that requester.
- Sits between requesting datapath units and the single multiplier instance.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 64: maximum WAIT cycles before the operation is aborted with an error.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester, held high until its ack.
- req_mult  in  16*NUM_REQ  requester i multiplicand at [16i+15:16i].
- req_mcand  in  4*NUM_REQ  requester i multiplier at [4i+3:4i].
- ack  out  NUM_REQ  one-cycle completion pulse to the served requester.
- result  out  20  product; valid only while any ack bit is high.
- err  out  1  timeout flag; valid only while any ack bit is high.
- busy  out  1  high in every state except IDLE.
- grant_id  out  3  index of the current or last granted requester.
- mul_St  out  1  start pulse to the multiplier.
- mul_Mult  out  16  multiplicand to the multiplier.
- mul_Mcand  out  4  multiplier operand to the multiplier.
- mul_product  in  20  multiplier result.
- mul_Done  in  1  multiplier completion.

Behaviour:
- Reset values: ack=0, result=0, err=0, busy=0, grant_id=0, mul_St=0, mul_Mult=0, mul_Mcand=0, state=IDLE, rr pointer=0, timeout counter=0.
- States: IDLE, ISSUE, BLANK, WAIT, RESP.
- IDLE: if any req is high, choose the winner by round-robin starting at the rr pointer. Register grant_id, latch that requester's operands into mul_Mult/mul_Mcand, then go to ISSUE. If no req is high, stay in IDLE.
- ISSUE (1 cycle): mul_St=1. Go to BLANK.
- BLANK (1 cycle): mul_St=0 and mul_Done is ignored, because Done may still be high from the previous operation. Clear the counter. Go to WAIT.
- WAIT: increment the counter each cycle.
  - If mul_Done=1, capture mul_product into result, set err=0, go to RESP.
  - Else if counter reaches TIMEOUT-1, set result=0, err=1, go to RESP.
  - If Done and timeout occur in the same cycle, Done wins.
- RESP (1 cycle): ack[grant_id]=1. Update rr pointer to (grant_id+1) mod NUM_REQ. Go to IDLE. result and err hold their values until the next RESP.
- mul_Mult and mul_Mcand stay stable from ISSUE through the end of WAIT. The multiplier never sees operand changes mid-operation.
- Latency: req sampled in IDLE at cycle t gives mul_St at t+1. If Done is sampled at cycle d (d ≥ t+3), ack and result appear at d+1. Back-to-back grants are separated by exactly one IDLE cycle.
- Request rules:
  - A req that stays high in the IDLE cycle after its own ack counts as a new request.
  - Requester operand or req changes after the grant are ignored; the granted operation always completes and is always acked.
  - Deasserting req before ack is not supported; ack is still pulsed.
- Arithmetic: unsigned 16x4, and the 20-bit result never overflows.
- Reset mid-operation (any state): return to reset values on the next edge and drop mul_St immediately. No ack is issued for the aborted operation. The external multiplier is not reset by this block; the BLANK cycle masks its stale Done on the next issue.

Test Plan:
- Single request: req0=1, operands 18 and 5 -> mul_St pulses for one cycle; ack[0] pulses with result=90, err=0; busy falls the cycle after ack.
- Contention: req0 (20, 8) and req1 (18, 5) asserted in the same cycle -> ack[0] first with result=160, then ack[1] with result=90; grant_id sequence is 0, 1.
- Round-robin: all four reqs held high continuously for 8 grants -> grant order 0,1,2,3,0,1,2,3; no requester is granted twice before every other requester has been granted once.
- Boundary: operands 65535 and 15 -> result=983025, err=0; operands changed at the input during WAIT -> mul_Mult and mul_Mcand stay unchanged and the result is still correct.
- Timeout: multiplier model never asserts Done -> ack with err=1, result=0 after 64 WAIT cycles. A stale Done held high through ISSUE/BLANK with no new completion -> that Done is ignored until WAIT.
- Reset during WAIT: reset=1 for one cycle -> no ack; state returns to IDLE; next req1 (20, 8) is granted first (rr pointer=0 scan) with result=160.
